// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: one decoded address window with read-only bottom words,
// programmable wait states on OKAY transfers and two-cycle ERROR responses.
module ahb_slave_mem #(
    parameter int SLAVE_IDX   = 0,
    parameter int MEM_DEPTH   = 1024,
    parameter int ROM_WORDS   = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    localparam logic [2:0]  WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [21:0] WINDOW    = 22'(SLAVE_IDX);
    localparam logic [31:0] DEPTH_W   = 32'(MEM_DEPTH);
    localparam logic [31:0] ROM_W     = 32'(ROM_WORDS);

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [9:0]  addr_r;
    logic        write_r;
    logic [31:0] mem_r [0:MEM_DEPTH-1];

    logic        open_s;
    logic        accept_s;
    logic        err_s;
    logic        wr_now_s;
    logic [9:0]  rd_off_s;
    logic [31:0] rd_data_s;
    logic        unused_s;

    assign unused_s = ^{HTRANS[0], HBURST};

    // Address-phase acceptance and error classification of the transfer on the bus
    always_comb begin
        open_s   = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR2);
        accept_s = open_s && HSEL && HREADYIN && HTRANS[1];
        err_s    = (HADDR[31:10] != WINDOW)
                || (HSIZE != 3'b010)
                || ({22'd0, HADDR[9:0]} >= DEPTH_W)
                || (HWRITE && ({22'd0, HADDR[9:0]} < ROM_W));
    end

    // Read-data source; a write finishing this cycle is forwarded to a read of the same word
    always_comb begin
        wr_now_s = (state_r == ST_DONE) && write_r;
        if (state_r == ST_WAIT) begin
            rd_off_s = addr_r;
        end else begin
            rd_off_s = HADDR[9:0];
        end
        if (wr_now_s && (addr_r == rd_off_s)) begin
            rd_data_s = HWDATA;
        end else begin
            rd_data_s = mem_r[rd_off_s];
        end
    end

    // Storage array, written only at the end of an OKAY write data phase
    always_ff @(posedge HCLK) begin
        if (wr_now_s) begin
            mem_r[addr_r] <= HWDATA;
        end
    end

    // Transfer FSM with registered bus responses
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            addr_r  <= 10'd0;
            write_r <= 1'b0;
            HREADY  <= 1'b1;
            HRESP   <= 1'b0;
            HRDATA  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (accept_s) begin
                        addr_r  <= HADDR[9:0];
                        write_r <= HWRITE;
                        if (err_s) begin
                            state_r <= ST_ERR1;
                            HREADY  <= 1'b0;
                            HRESP   <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_INIT;
                            HREADY  <= 1'b0;
                            HRESP   <= 1'b0;
                        end else begin
                            state_r <= ST_DONE;
                            HREADY  <= 1'b1;
                            HRESP   <= 1'b0;
                            if (!HWRITE) begin
                                HRDATA <= rd_data_s;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        HREADY  <= 1'b1;
                        HRESP   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_r <= ST_DONE;
                        HREADY  <= 1'b1;
                        HRESP   <= 1'b0;
                        if (!write_r) begin
                            HRDATA <= rd_data_s;
                        end
                    end else begin
                        cnt_r  <= cnt_r - 3'd1;
                        HREADY <= 1'b0;
                        HRESP  <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    state_r <= ST_ERR2;
                    HREADY  <= 1'b1;
                    HRESP   <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    HREADY  <= 1'b1;
                    HRESP   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a pipelined bus master drives two slaves (0 and 1 wait
// states) and checks every data phase against a word-level memory model.
module tb_ahb_slave_mem;

    logic        HCLK = 1'b0;
    logic        reset;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready0, hresp0, hready1, hresp1;
    logic [31:0] hrdata0, hrdata1;

    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(.SLAVE_IDX(0), .MEM_DEPTH(1024), .ROM_WORDS(4), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYIN(hready0), .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb_slave_mem #(.SLAVE_IDX(0), .MEM_DEPTH(1024), .ROM_WORDS(4), .WAIT_STATES(1)) dut1 (
        .HCLK(HCLK), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYIN(hready1), .HREADY(hready1), .HRESP(hresp1), .HRDATA(hrdata1)
    );

    int          n_assert, n_fail;
    int          sel;
    logic [2:0]  burst;
    int          n;
    logic [1:0]  q_trans [64];
    logic        q_write [64];
    logic [31:0] q_addr  [64];
    logic [2:0]  q_size  [64];
    logic [31:0] q_wdata [64];
    logic [31:0] mdl   [2][1024];
    bit          known [2][1024];
    logic [31:0] last_rd [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_hready();
        return (sel == 1) ? hready1 : hready0;
    endfunction

    function automatic logic cur_hresp();
        return (sel == 1) ? hresp1 : hresp0;
    endfunction

    function automatic logic [31:0] cur_hrdata();
        return (sel == 1) ? hrdata1 : hrdata0;
    endfunction

    task automatic push(input logic [1:0] tr, input logic wr, input logic [31:0] ad,
                        input logic [2:0] sz, input logic [31:0] wd);
        q_trans[n] = tr;
        q_write[n] = wr;
        q_addr[n]  = ad;
        q_size[n]  = sz;
        q_wdata[n] = wd;
        n++;
    endtask

    task automatic drive_ap(input int i);
        haddr  = q_addr[i];
        hwrite = q_write[i];
        htrans = q_trans[i];
        hsize  = q_size[i];
        hburst = burst;
        hsel0  = (sel == 0);
        hsel1  = (sel == 1);
    endtask

    task automatic drive_idle();
        haddr  = 32'd0;
        hwrite = 1'b0;
        htrans = 2'b00;
        hsize  = 3'b010;
        hburst = 3'b000;
        hsel0  = 1'b0;
        hsel1  = 1'b0;
    endtask

    // Expected outcome of one data phase, derived from the transfer itself
    task automatic complete(input int i, input int waits);
        logic       act, err;
        logic [9:0] off;
        logic [31:0] exp_waits;
        act = q_trans[i][1];
        off = q_addr[i][9:0];
        err = act && ((q_addr[i][31:10] != 22'd0) || (q_size[i] != 3'b010)
                      || (int'(off) >= 1024) || (q_write[i] && int'(off) < 4));
        if (!act)     exp_waits = 32'd0;
        else if (err) exp_waits = 32'd1;
        else          exp_waits = 32'(sel);
        check($sformatf("waits[%0d] dut%0d", i, sel), 32'(waits), exp_waits);
        check($sformatf("hresp[%0d] dut%0d", i, sel), 32'(cur_hresp()), 32'(err));
        if (act && !err) begin
            if (q_write[i]) begin
                mdl[sel][off]   = q_wdata[i];
                known[sel][off] = 1'b1;
            end else begin
                if (known[sel][off]) begin
                    check($sformatf("hrdata[%0d] dut%0d @%h", i, sel, off), cur_hrdata(), mdl[sel][off]);
                end else begin
                    mdl[sel][off]   = cur_hrdata();
                    known[sel][off] = 1'b1;
                end
                last_rd[sel] = mdl[sel][off];
            end
        end
    endtask

    // Pipelined master: address phase of transfer k overlaps data phase of k-1
    task automatic run();
        int ap, dpi, waits;
        bit dpv, rdy, done;
        ap = 0; dpi = 0; waits = 0; dpv = 1'b0; done = 1'b0;
        drive_ap(0);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge HCLK);
            rdy = cur_hready();
            if (dpv) begin
                if (!rdy) begin
                    waits++;
                end else begin
                    complete(dpi, waits);
                    dpv = 1'b0;
                end
            end
            if (rdy) begin
                if (ap >= n && !dpv) begin
                    done = 1'b1;
                end else begin
                    @(posedge HCLK);
                    #1;
                    if (ap < n) begin
                        dpi    = ap;
                        dpv    = 1'b1;
                        waits  = 0;
                        hwdata = q_write[ap] ? q_wdata[ap] : 32'h0;
                        ap++;
                    end
                    if (ap < n) drive_ap(ap);
                    else        drive_idle();
                end
            end
        end
        check("run_complete", 32'(done), 32'd1);
        n = 0;
    endtask

    initial begin
        logic [1:0]  tr;
        logic        wr;
        logic [31:0] ad;
        logic [2:0]  sz;
        int          kind;

        n_assert = 0; n_fail = 0; n = 0; sel = 1; burst = 3'b000;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 1024; w++) known[s][w] = 1'b0;
        reset = 1'b1; hwdata = 32'd0;
        drive_idle();
        repeat (3) @(negedge HCLK);
        reset = 1'b0;
        @(negedge HCLK);
        check("rst_hready0", 32'(hready0), 32'd1);
        check("rst_hresp0",  32'(hresp0),  32'd0);
        check("rst_hrdata0", hrdata0,      32'd0);
        check("rst_hready1", 32'(hready1), 32'd1);
        check("rst_hresp1",  32'(hresp1),  32'd0);
        check("rst_hrdata1", hrdata1,      32'd0);

        // Write then read with one wait state
        sel = 1;
        push(2'b10, 1'b1, 32'h010, 3'b010, 32'hA5A5_0001);
        push(2'b10, 1'b0, 32'h010, 3'b010, 32'h0);
        run();
        check("hold_010", cur_hrdata(), 32'hA5A5_0001);

        // ROM write is rejected and leaves the word untouched
        push(2'b10, 1'b0, 32'h002, 3'b010, 32'h0);
        push(2'b10, 1'b1, 32'h002, 3'b010, 32'hDEAD_BEEF);
        push(2'b10, 1'b0, 32'h002, 3'b010, 32'h0);
        run();

        // Window miss aliasing offset 0 must not write
        push(2'b10, 1'b0, 32'h000, 3'b010, 32'h0);
        push(2'b10, 1'b1, 32'h800, 3'b010, 32'h1234_5678);
        push(2'b10, 1'b0, 32'h000, 3'b010, 32'h0);
        run();

        // INCR4 write with a BUSY beat, then INCR4 read-back
        burst = 3'b011;
        push(2'b10, 1'b1, 32'h020, 3'b010, 32'h0B0B_0020);
        push(2'b11, 1'b1, 32'h021, 3'b010, 32'h0B0B_0021);
        push(2'b01, 1'b1, 32'h022, 3'b010, 32'hFFFF_FFFF);
        push(2'b11, 1'b1, 32'h022, 3'b010, 32'h0B0B_0022);
        push(2'b11, 1'b1, 32'h023, 3'b010, 32'h0B0B_0023);
        run();
        push(2'b10, 1'b0, 32'h020, 3'b010, 32'h0);
        push(2'b11, 1'b0, 32'h021, 3'b010, 32'h0);
        push(2'b11, 1'b0, 32'h022, 3'b010, 32'h0);
        push(2'b11, 1'b0, 32'h023, 3'b010, 32'h0);
        run();
        check("hold_023", cur_hrdata(), 32'h0B0B_0023);
        burst = 3'b000;

        // Back-to-back write/read with zero wait states
        sel = 0;
        push(2'b10, 1'b1, 32'h030, 3'b010, 32'hCAFE_0030);
        push(2'b10, 1'b0, 32'h030, 3'b010, 32'h0);
        run();
        check("bypass_030", cur_hrdata(), 32'hCAFE_0030);

        // Reset during the wait cycle of a write
        sel = 1;
        push(2'b10, 1'b1, 32'h040, 3'b010, 32'h1111_0040);
        run();
        haddr = 32'h040; hwrite = 1'b1; htrans = 2'b10; hsize = 3'b010; hsel1 = 1'b1;
        @(posedge HCLK);
        #1;
        hwdata = 32'h2222_0040;
        drive_idle();
        @(negedge HCLK);
        check("wait_hready", 32'(hready1), 32'd0);
        reset = 1'b1;
        #1;
        check("async_hready", 32'(hready1), 32'd1);
        check("async_hresp",  32'(hresp1),  32'd0);
        check("async_hrdata", hrdata1,      32'd0);
        @(negedge HCLK);
        reset = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        push(2'b10, 1'b0, 32'h040, 3'b010, 32'h0);
        run();
        check("lost_write_040", cur_hrdata(), 32'h1111_0040);

        // Randomized traffic on both slaves
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int chunk = 0; chunk < 2; chunk++) begin
                for (int k = 0; k < 30; k++) begin
                    kind = int'($urandom_range(0, 9));
                    wr   = 1'($urandom_range(0, 1));
                    tr   = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                    ad   = {22'd0, 10'($urandom_range(0, 15))};
                    sz   = 3'b010;
                    if (kind == 0)      tr = 2'($urandom_range(0, 1));
                    else if (kind == 1) ad[31:10] = 22'($urandom_range(1, 7));
                    else if (kind == 2) sz = 3'b001;
                    push(tr, wr, ad, sz, $urandom());
                end
                run();
                check($sformatf("hold_rand dut%0d", s), cur_hrdata(), last_rd[s]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
